// File: rtl/dct2_job_arbiter.sv
// Round-robin arbiter sharing one 2D DCT2 core between two requesters.
// Sequences each granted job through a vertical pass, a horizontal pass and an output drain.
module dct2_job_arbiter #(
    parameter int DRAIN_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_size,
    output logic [1:0] req_ready,
    input  logic       core_stall,
    output logic       core_start,
    output logic [1:0] core_size,
    output logic       core_dir,
    output logic       core_src,
    output logic       busy,
    output logic       done,
    output logic       done_src
);

    // state | meaning
    // IDLE  | no job active, arbitration open
    // RUN   | 2T counted cycles: first T vertical, last T horizontal
    // DRAIN | DRAIN_CYC counted cycles of output-pipeline flush
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    localparam logic       NO_DRAIN   = (DRAIN_CYC == 0);
    localparam logic [6:0] DRAIN_LOAD = (DRAIN_CYC > 0) ? 7'(DRAIN_CYC - 1) : 7'd0;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       ptr_q, ptr_d;
    logic       src_q, src_d;
    logic [1:0] size_q, size_d;
    logic       first_q, first_d;

    logic [1:0] grant;
    logic [1:0] sel_size;
    logic [6:0] t_val;
    logic       last_cyc;

    always_comb begin
        grant = 2'b00;
        if (state_q == ST_IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel_size = grant[1] ? req_size[3:2] : req_size[1:0];
    assign t_val    = 7'd4 << size_q;

    // Final counted cycle of a job; a stall here postpones it.
    assign last_cyc = (cnt_q == 7'd0) && !core_stall &&
                      ((state_q == ST_DRAIN) || ((state_q == ST_RUN) && NO_DRAIN));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        size_d  = size_q;
        first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    state_d = ST_RUN;
                    cnt_d   = (7'd8 << sel_size) - 7'd1;
                    size_d  = sel_size;
                    src_d   = grant[1];
                    ptr_d   = ~grant[1];
                    first_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!core_stall) begin
                    if (cnt_q == 7'd0) begin
                        state_d = NO_DRAIN ? ST_IDLE : ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!core_stall) begin
                    if (cnt_q == 7'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 7'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 7'd0;
            ptr_q   <= 1'b0;
            src_q   <= 1'b0;
            size_q  <= 2'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            size_q  <= size_d;
            first_q <= first_d;
        end
    end

    assign req_ready  = grant;
    assign core_start = (state_q == ST_RUN) && first_q;
    assign core_size  = size_q;
    assign core_dir   = (state_q == ST_RUN) && (cnt_q >= t_val);
    assign core_src   = src_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = last_cyc;
    assign done_src   = last_cyc && src_q;

endmodule
